// File: rtl/eu_operand_sched.sv
// Per-execution-unit operand scheduler: collects two operands from immediate,
// local cache or the shared foreign bus, then hands them to the ALU.
module eu_operand_sched #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned EU_IDX  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic              op0_isreg_i,
  input  logic              op1_isreg_i,
  input  logic              op0_isforeign_i,
  input  logic              op1_isforeign_i,
  input  logic [DATA_W-1:0] op0_imm_i,
  input  logic [DATA_W-1:0] op1_imm_i,
  output logic              lop0_req_o,
  output logic              lop1_req_o,
  input  logic [DATA_W-1:0] lop0_data_i,
  input  logic [DATA_W-1:0] lop1_data_i,
  input  logic              lop0_success_i,
  input  logic              lop1_success_i,
  output logic              fop_req_o,
  output logic              fop_sel_o,
  output logic              fop_tag_o,
  input  logic              fop_grant_i,
  input  logic              fop_success_i,
  input  logic              fop_tag_i,
  input  logic [DATA_W-1:0] fop_data_i,
  output logic              alu_valid_o,
  input  logic              alu_ready_i,
  output logic [DATA_W-1:0] alu_op0_o,
  output logic [DATA_W-1:0] alu_op1_o,
  output logic [7:0]        retry_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // Last timeout-counter value before the wait is declared lost.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  // The unit index is informational only; nothing is generated from it.
  if (EU_IDX > 32'd65535) begin : g_eu_idx_unused
  end

  state_t              state_r, state_nxt_s;
  logic                isreg0_r, isreg1_r, isfor0_r, isfor1_r;
  logic                isreg0_nxt_s, isreg1_nxt_s, isfor0_nxt_s, isfor1_nxt_s;
  logic                cap0_r, cap1_r, cap0_nxt_s, cap1_nxt_s;
  logic [DATA_W-1:0]   op0_r, op1_r, op0_nxt_s, op1_nxt_s;
  logic [DATA_W-1:0]   alu_op0_r, alu_op1_r, alu_op0_nxt_s, alu_op1_nxt_s;
  logic                out_r, out_nxt_s;
  logic                sel_r, sel_nxt_s;
  logic                tag_r, tag_nxt_s;
  logic [7:0]          tmo_r, tmo_nxt_s;
  logic [7:0]          retry_r, retry_nxt_s;

  logic                in_fetch_s;
  logic                lpend0_s, lpend1_s, fpend0_s, fpend1_s;
  logic                accept_s, fop_accept_s, timeout_s;

  assign in_fetch_s   = (state_r == ST_FETCH);
  assign lpend0_s     = isreg0_r & ~isfor0_r & ~cap0_r;
  assign lpend1_s     = isreg1_r & ~isfor1_r & ~cap1_r;
  assign fpend0_s     = isreg0_r &  isfor0_r & ~cap0_r;
  assign fpend1_s     = isreg1_r &  isfor1_r & ~cap1_r;

  assign instr_ready_o = (state_r == ST_IDLE) & ~flush_i & ~reset;
  assign lop0_req_o    = in_fetch_s & lpend0_s;
  assign lop1_req_o    = in_fetch_s & lpend1_s;
  // op0 wins arbitration; op1 is only chosen when op0 needs nothing foreign.
  assign fop_req_o     = in_fetch_s & ~out_r & (fpend0_s | fpend1_s);
  assign fop_sel_o     = fop_req_o & ~fpend0_s;
  assign fop_tag_o     = tag_r;
  assign alu_valid_o   = (state_r == ST_ISSUE);
  assign alu_op0_o     = alu_op0_r;
  assign alu_op1_o     = alu_op1_r;
  assign retry_cnt_o   = retry_r;

  assign accept_s      = instr_valid_i & instr_ready_o;
  // A response only counts against the request currently in flight.
  assign fop_accept_s  = in_fetch_s & out_r & fop_success_i & (fop_tag_i == tag_r);
  assign timeout_s     = in_fetch_s & out_r & ~fop_accept_s & (tmo_r == TMO_LAST);

  // Next-state, operand capture, foreign-bus bookkeeping and ALU operand load.
  always_comb begin
    state_nxt_s   = state_r;
    isreg0_nxt_s  = isreg0_r;
    isreg1_nxt_s  = isreg1_r;
    isfor0_nxt_s  = isfor0_r;
    isfor1_nxt_s  = isfor1_r;
    cap0_nxt_s    = cap0_r;
    cap1_nxt_s    = cap1_r;
    op0_nxt_s     = op0_r;
    op1_nxt_s     = op1_r;
    out_nxt_s     = out_r;
    sel_nxt_s     = sel_r;
    tag_nxt_s     = tag_r;
    tmo_nxt_s     = tmo_r;
    retry_nxt_s   = retry_r;
    alu_op0_nxt_s = alu_op0_r;
    alu_op1_nxt_s = alu_op1_r;

    if (flush_i) begin
      state_nxt_s = ST_IDLE;
      cap0_nxt_s  = 1'b0;
      cap1_nxt_s  = 1'b0;
      out_nxt_s   = 1'b0;
      tag_nxt_s   = ~tag_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            isreg0_nxt_s = op0_isreg_i;
            isreg1_nxt_s = op1_isreg_i;
            isfor0_nxt_s = op0_isforeign_i;
            isfor1_nxt_s = op1_isforeign_i;
            cap0_nxt_s   = ~op0_isreg_i;
            cap1_nxt_s   = ~op1_isreg_i;
            op0_nxt_s    = op0_isreg_i ? op0_r : op0_imm_i;
            op1_nxt_s    = op1_isreg_i ? op1_r : op1_imm_i;
            tag_nxt_s    = ~tag_r;
            state_nxt_s  = (~op0_isreg_i & ~op1_isreg_i) ? ST_ISSUE : ST_FETCH;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (lop0_req_o & lop0_success_i) begin
            op0_nxt_s  = lop0_data_i;
            cap0_nxt_s = 1'b1;
          end else begin
            cap0_nxt_s = cap0_r;
          end
          if (lop1_req_o & lop1_success_i) begin
            op1_nxt_s  = lop1_data_i;
            cap1_nxt_s = 1'b1;
          end else begin
            cap1_nxt_s = cap1_r;
          end
          if (fop_accept_s) begin
            out_nxt_s = 1'b0;
            if (sel_r) begin
              op1_nxt_s  = fop_data_i;
              cap1_nxt_s = 1'b1;
            end else begin
              op0_nxt_s  = fop_data_i;
              cap0_nxt_s = 1'b1;
            end
          end else if (timeout_s) begin
            out_nxt_s   = 1'b0;
            tag_nxt_s   = ~tag_r;
            retry_nxt_s = (retry_r == 8'hFF) ? retry_r : retry_r + 8'd1;
          end else if (fop_req_o & fop_grant_i) begin
            out_nxt_s = 1'b1;
            sel_nxt_s = fop_sel_o;
            tmo_nxt_s = 8'd0;
          end else if (out_r) begin
            tmo_nxt_s = tmo_r + 8'd1;
          end else begin
            tmo_nxt_s = tmo_r;
          end
          state_nxt_s = (cap0_nxt_s & cap1_nxt_s) ? ST_ISSUE : ST_FETCH;
        end
        ST_ISSUE: begin
          if (alu_ready_i) begin
            cap0_nxt_s  = 1'b0;
            cap1_nxt_s  = 1'b0;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cap0_nxt_s  = 1'b0;
          cap1_nxt_s  = 1'b0;
          out_nxt_s   = 1'b0;
        end
      endcase
    end

    // ALU operands change only on entry to ISSUE so they hold elsewhere.
    if ((state_nxt_s == ST_ISSUE) && (state_r != ST_ISSUE)) begin
      alu_op0_nxt_s = op0_nxt_s;
      alu_op1_nxt_s = op1_nxt_s;
    end else begin
      alu_op0_nxt_s = alu_op0_r;
      alu_op1_nxt_s = alu_op1_r;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      isreg0_r  <= 1'b0;
      isreg1_r  <= 1'b0;
      isfor0_r  <= 1'b0;
      isfor1_r  <= 1'b0;
      cap0_r    <= 1'b0;
      cap1_r    <= 1'b0;
      op0_r     <= '0;
      op1_r     <= '0;
      alu_op0_r <= '0;
      alu_op1_r <= '0;
      out_r     <= 1'b0;
      sel_r     <= 1'b0;
      tag_r     <= 1'b0;
      tmo_r     <= 8'd0;
      retry_r   <= 8'd0;
    end else begin
      state_r   <= state_nxt_s;
      isreg0_r  <= isreg0_nxt_s;
      isreg1_r  <= isreg1_nxt_s;
      isfor0_r  <= isfor0_nxt_s;
      isfor1_r  <= isfor1_nxt_s;
      cap0_r    <= cap0_nxt_s;
      cap1_r    <= cap1_nxt_s;
      op0_r     <= op0_nxt_s;
      op1_r     <= op1_nxt_s;
      alu_op0_r <= alu_op0_nxt_s;
      alu_op1_r <= alu_op1_nxt_s;
      out_r     <= out_nxt_s;
      sel_r     <= sel_nxt_s;
      tag_r     <= tag_nxt_s;
      tmo_r     <= tmo_nxt_s;
      retry_r   <= retry_nxt_s;
    end
  end

endmodule

// File: tb/tb_eu_operand_sched.sv
// Directed bench for eu_operand_sched with a transaction-level reference model.
module tb_eu_operand_sched;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush_i;
  logic          instr_valid_i;
  logic          instr_ready_o;
  logic          op0_isreg_i, op1_isreg_i, op0_isforeign_i, op1_isforeign_i;
  logic [DW-1:0] op0_imm_i, op1_imm_i;
  logic          lop0_req_o, lop1_req_o;
  logic [DW-1:0] lop0_data_i, lop1_data_i;
  logic          lop0_success_i, lop1_success_i;
  logic          fop_req_o, fop_sel_o, fop_tag_o;
  logic          fop_grant_i, fop_success_i, fop_tag_i;
  logic [DW-1:0] fop_data_i;
  logic          alu_valid_o, alu_ready_i;
  logic [DW-1:0] alu_op0_o, alu_op1_o;
  logic [7:0]    retry_cnt_o;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: expected ALU operand pairs in issue order, current
  // request tag (parity of accepts, timeouts and flushes) and retry count.
  logic [DW-1:0] exp_op0_q[$];
  logic [DW-1:0] exp_op1_q[$];
  logic          exp_tag   = 1'b0;
  logic [7:0]    exp_retry = 8'd0;
  bit            chk_en    = 1'b0;
  logic          tag_a;

  eu_operand_sched #(.DATA_W(DW), .TIMEOUT(3), .EU_IDX(0)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .op0_isreg_i(op0_isreg_i), .op1_isreg_i(op1_isreg_i),
    .op0_isforeign_i(op0_isforeign_i), .op1_isforeign_i(op1_isforeign_i),
    .op0_imm_i(op0_imm_i), .op1_imm_i(op1_imm_i),
    .lop0_req_o(lop0_req_o), .lop1_req_o(lop1_req_o),
    .lop0_data_i(lop0_data_i), .lop1_data_i(lop1_data_i),
    .lop0_success_i(lop0_success_i), .lop1_success_i(lop1_success_i),
    .fop_req_o(fop_req_o), .fop_sel_o(fop_sel_o), .fop_tag_o(fop_tag_o),
    .fop_grant_i(fop_grant_i), .fop_success_i(fop_success_i),
    .fop_tag_i(fop_tag_i), .fop_data_i(fop_data_i),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
    .alu_op0_o(alu_op0_o), .alu_op1_o(alu_op1_o),
    .retry_cnt_o(retry_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic set_instr(input logic r0, input logic f0, input logic r1, input logic f1,
                           input logic [DW-1:0] i0, input logic [DW-1:0] i1);
    instr_valid_i   = 1'b1;
    op0_isreg_i     = r0;
    op0_isforeign_i = f0;
    op1_isreg_i     = r1;
    op1_isforeign_i = f1;
    op0_imm_i       = i0;
    op1_imm_i       = i1;
  endtask

  task automatic fresp(input logic v, input logic t, input logic [DW-1:0] d);
    fop_success_i = v;
    fop_tag_i     = t;
    fop_data_i    = d;
  endtask

  // Every-cycle comparison of the DUT against the reference model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("retry_cnt", retry_cnt_o, exp_retry);
      chk("fop_tag", fop_tag_o, exp_tag);
      if (alu_valid_o) begin
        if (exp_op0_q.size() == 0) begin
          chk("alu_valid_unexpected", alu_valid_o, 1'b0);
        end else begin
          chk("alu_op0", alu_op0_o, exp_op0_q[0]);
          chk("alu_op1", alu_op1_o, exp_op1_q[0]);
          if (alu_ready_i) begin
            void'(exp_op0_q.pop_front());
            void'(exp_op1_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush_i = 1'b0; instr_valid_i = 1'b0;
    op0_isreg_i = 1'b0; op1_isreg_i = 1'b0; op0_isforeign_i = 1'b0; op1_isforeign_i = 1'b0;
    op0_imm_i = 16'h0; op1_imm_i = 16'h0;
    lop0_data_i = 16'h0; lop1_data_i = 16'h0; lop0_success_i = 1'b0; lop1_success_i = 1'b0;
    fop_grant_i = 1'b0; fresp(1'b0, 1'b0, 16'h0); alu_ready_i = 1'b0;

    // Reset state
    step(); step(); look();
    chk("rst_ready", instr_ready_o, 1'b0);
    chk("rst_valid", alu_valid_o, 1'b0);
    chk("rst_fop_req", fop_req_o, 1'b0);
    chk("rst_lop0_req", lop0_req_o, 1'b0);
    chk("rst_retry", retry_cnt_o, 8'd0);
    chk("rst_tag", fop_tag_o, 1'b0);
    chk("rst_op0", alu_op0_o, 16'h0);
    reset = 1'b0; exp_tag = 1'b0; exp_retry = 8'd0; chk_en = 1'b1;
    step(); look();
    chk("idle_ready", instr_ready_o, 1'b1);

    // S1: both immediate
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0034); look();
    chk("s1_accept_ready", instr_ready_o, 1'b1);
    step(); instr_valid_i = 1'b0; exp_tag = ~exp_tag;
    exp_op0_q.push_back(16'h0012); exp_op1_q.push_back(16'h0034);
    alu_ready_i = 1'b1; look();
    chk("s1_valid", alu_valid_o, 1'b1);
    chk("s1_op0_lit", alu_op0_o, 16'h0012);
    chk("s1_op1_lit", alu_op1_o, 16'h0034);
    chk("s1_ready_in_issue", instr_ready_o, 1'b0);
    step(); alu_ready_i = 1'b0; look();
    chk("s1_ready_back", instr_ready_o, 1'b1);
    chk("s1_valid_drop", alu_valid_o, 1'b0);

    // S2: op0 local, op1 foreign
    set_instr(1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
    step(); instr_valid_i = 1'b0; exp_tag = ~exp_tag;
    exp_op0_q.push_back(16'hAAAA); exp_op1_q.push_back(16'h5555);
    fop_grant_i = 1'b1; lop0_data_i = 16'hBEEF; look();
    chk("s2_lop0_req", lop0_req_o, 1'b1);
    chk("s2_lop1_req", lop1_req_o, 1'b0);
    chk("s2_fop_req", fop_req_o, 1'b1);
    chk("s2_fop_sel", fop_sel_o, 1'b1);
    chk("s2_tag_lit", fop_tag_o, 1'b0);
    step(); fop_grant_i = 1'b0; lop0_success_i = 1'b1; lop0_data_i = 16'hAAAA; look();
    chk("s2_fop_req_drop", fop_req_o, 1'b0);
    chk("s2_lop0_req_hold", lop0_req_o, 1'b1);
    step(); lop0_success_i = 1'b0; lop0_data_i = 16'h0; look();
    chk("s2_lop0_req_done", lop0_req_o, 1'b0);
    chk("s2_fop_req_out", fop_req_o, 1'b0);
    chk("s2_not_valid", alu_valid_o, 1'b0);
    step(); fresp(1'b1, exp_tag, 16'h5555); look();
    chk("s2_not_valid_resp", alu_valid_o, 1'b0);
    step(); fresp(1'b0, 1'b0, 16'h0); alu_ready_i = 1'b1; look();
    chk("s2_valid", alu_valid_o, 1'b1);
    chk("s2_op0_lit", alu_op0_o, 16'hAAAA);
    chk("s2_op1_lit", alu_op1_o, 16'h5555);
    step(); alu_ready_i = 1'b0;

    // S3: both foreign, op0 first, stray and mismatched responses ignored
    set_instr(1'b1, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0);
    step(); instr_valid_i = 1'b0; exp_tag = ~exp_tag;
    exp_op0_q.push_back(16'h1111); exp_op1_q.push_back(16'h2222);
    fop_grant_i = 1'b1; fresp(1'b1, exp_tag, 16'hBAD1); look();
    chk("s3_req0", fop_req_o, 1'b1);
    chk("s3_sel0", fop_sel_o, 1'b0);
    chk("s3_lop0_req", lop0_req_o, 1'b0);
    step(); fop_grant_i = 1'b0; fresp(1'b1, exp_tag, 16'h1111); look();
    chk("s3_req_drop0", fop_req_o, 1'b0);
    step(); fresp(1'b0, 1'b0, 16'h0); fop_grant_i = 1'b1; look();
    chk("s3_req1", fop_req_o, 1'b1);
    chk("s3_sel1", fop_sel_o, 1'b1);
    step(); fop_grant_i = 1'b0; fresp(1'b1, ~exp_tag, 16'hDEAD); look();
    chk("s3_req_drop1", fop_req_o, 1'b0);
    step(); fresp(1'b1, exp_tag, 16'h2222);
    step(); fresp(1'b0, 1'b0, 16'h0); alu_ready_i = 1'b1; look();
    chk("s3_valid", alu_valid_o, 1'b1);
    chk("s3_op0_lit", alu_op0_o, 16'h1111);
    chk("s3_op1_lit", alu_op1_o, 16'h2222);
    step(); alu_ready_i = 1'b0;

    // S4: timeout, re-request with toggled tag, late old-tag response ignored
    set_instr(1'b0, 1'b0, 1'b1, 1'b1, 16'h0777, 16'h0);
    step(); instr_valid_i = 1'b0; exp_tag = ~exp_tag;
    exp_op0_q.push_back(16'h0777); exp_op1_q.push_back(16'h3333);
    fop_grant_i = 1'b1; look();
    chk("s4_req", fop_req_o, 1'b1);
    chk("s4_sel", fop_sel_o, 1'b1);
    step(); fop_grant_i = 1'b0; look();
    chk("s4_req_g1", fop_req_o, 1'b0);
    step(); look();
    chk("s4_req_g2", fop_req_o, 1'b0);
    step(); look();
    chk("s4_req_g3", fop_req_o, 1'b0);
    chk("s4_retry0_lit", retry_cnt_o, 8'd0);
    step(); exp_tag = ~exp_tag; exp_retry = exp_retry + 8'd1;
    fresp(1'b1, ~exp_tag, 16'hDEAD); fop_grant_i = 1'b1; look();
    chk("s4_rereq", fop_req_o, 1'b1);
    chk("s4_rereq_sel", fop_sel_o, 1'b1);
    chk("s4_retry1_lit", retry_cnt_o, 8'd1);
    chk("s4_tag_lit", fop_tag_o, 1'b1);
    step(); fop_grant_i = 1'b0; fresp(1'b1, ~exp_tag, 16'hDEAD);
    step(); fresp(1'b1, exp_tag, 16'h3333);
    step(); fresp(1'b0, 1'b0, 16'h0); alu_ready_i = 1'b1; look();
    chk("s4_valid", alu_valid_o, 1'b1);
    chk("s4_op1_lit", alu_op1_o, 16'h3333);
    step(); alu_ready_i = 1'b0;

    // S5: flush with request outstanding, stale response on next instruction
    set_instr(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0101);
    step(); instr_valid_i = 1'b0; exp_tag = ~exp_tag; tag_a = exp_tag;
    fop_grant_i = 1'b1;
    step(); fop_grant_i = 1'b0; flush_i = 1'b1; look();
    chk("s5_flush_ready", instr_ready_o, 1'b0);
    step(); exp_tag = ~exp_tag;
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0); look();
    chk("s5_idle_flush_ready", instr_ready_o, 1'b0);
    chk("s5_idle_fop_req", fop_req_o, 1'b0);
    chk("s5_idle_valid", alu_valid_o, 1'b0);
    step(); exp_tag = ~exp_tag; flush_i = 1'b0; look();
    chk("s5_accept_ready", instr_ready_o, 1'b1);
    step(); instr_valid_i = 1'b0; exp_tag = ~exp_tag;
    exp_op0_q.push_back(16'h4444); exp_op1_q.push_back(16'h5656);
    fop_grant_i = 1'b1; look();
    chk("s5_req", fop_req_o, 1'b1);
    chk("s5_sel", fop_sel_o, 1'b0);
    chk("s5_lop1_req", lop1_req_o, 1'b1);
    step(); fop_grant_i = 1'b0; fresp(1'b1, tag_a, 16'hDEAD);
    step(); fresp(1'b1, exp_tag, 16'h4444); lop1_success_i = 1'b1; lop1_data_i = 16'h5656; look();
    chk("s5_not_valid", alu_valid_o, 1'b0);
    chk("s5_lop1_req_hold", lop1_req_o, 1'b1);
    step(); fresp(1'b0, 1'b0, 16'h0); lop1_success_i = 1'b0; lop1_data_i = 16'h0;
    for (int i = 0; i < 5; i++) begin
      look();
      chk("s5_stall_valid", alu_valid_o, 1'b1);
      chk("s5_stall_op0_lit", alu_op0_o, 16'h4444);
      chk("s5_stall_op1_lit", alu_op1_o, 16'h5656);
      step();
    end
    alu_ready_i = 1'b1; flush_i = 1'b1; look();
    chk("s5_flush_issue_valid", alu_valid_o, 1'b1);
    step(); exp_tag = ~exp_tag; alu_ready_i = 1'b0; flush_i = 1'b0; look();
    chk("s5_after_flush_valid", alu_valid_o, 1'b0);
    chk("s5_after_flush_ready", instr_ready_o, 1'b1);
    chk("s5_ops_hold", alu_op0_o, 16'h4444);

    // S6: reset mid-FETCH
    set_instr(1'b1, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0);
    step(); instr_valid_i = 1'b0; exp_tag = ~exp_tag; fop_grant_i = 1'b1;
    step(); fop_grant_i = 1'b0; reset = 1'b1;
    step(); exp_tag = 1'b0; exp_retry = 8'd0; look();
    chk("s6_ready", instr_ready_o, 1'b0);
    chk("s6_fop_req", fop_req_o, 1'b0);
    chk("s6_fop_sel", fop_sel_o, 1'b0);
    chk("s6_lop0_req", lop0_req_o, 1'b0);
    chk("s6_lop1_req", lop1_req_o, 1'b0);
    chk("s6_valid", alu_valid_o, 1'b0);
    chk("s6_op0", alu_op0_o, 16'h0);
    chk("s6_op1", alu_op1_o, 16'h0);
    chk("s6_retry_lit", retry_cnt_o, 8'd0);
    chk("s6_tag", fop_tag_o, 1'b0);
    reset = 1'b0;
    step(); look();
    chk("s6_ready_after", instr_ready_o, 1'b1);
    chk("sb_empty", exp_op0_q.size(), 32'd0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
